// File: rtl/api_pkg.sv
// Shared definitions for the host-command mapper: command codes, FSM states
// and argument field positions.
package api_pkg;

  typedef enum logic [5:0] {
    CMD_SET_OFFSET = 6'd1,
    CMD_LOAD_BEGIN = 6'd2,
    CMD_LOAD_END   = 6'd3,
    CMD_SET_PTR    = 6'd4,
    CMD_WRITE      = 6'd5,
    CMD_READ       = 6'd6,
    CMD_STATUS     = 6'd7
  } cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_RAM_WAIT
  } state_e;

  localparam int REGION_LSB    = 0;
  localparam int REGION_MSB    = 3;
  localparam int SHIFT_LSB     = 8;
  localparam int SHIFT_MSB     = 12;
  localparam int DROP_CNT_BITS = 8;

endpackage

// File: rtl/api_ram_port.sv
// Toggle-handshake SDRAM port. An issue pulse launches one access by toggling
// ram_req; the access completes when ram_ack has caught up with ram_req.
// Address, data and direction are held for the whole pending access.
module api_ram_port #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic                 issue_we,
  input  logic [ADDR_BITS-1:0] issue_addr,
  input  logic [DATA_BITS-1:0] issue_data,
  output logic                 done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 ram_req,
  input  logic                 ram_ack,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0] ram_data_write,
  input  logic [DATA_BITS-1:0] ram_data_read
);

  logic pending;

  assign done  = pending && (ram_ack == ram_req);
  assign rdata = ram_data_read;

  // Launch an access on issue, retire it when the acknowledge toggle matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending        <= 1'b0;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_address    <= '0;
      ram_data_write <= '0;
    end else if (issue) begin
      pending        <= 1'b1;
      ram_req        <= ~ram_req;
      ram_we         <= issue_we;
      ram_address    <= issue_addr;
      ram_data_write <= issue_data;
    end else if (done) begin
      pending        <= 1'b0;
    end
  end

endmodule

// File: rtl/api_mapper.sv
// Host-command decoder: region base offsets, load flag, auto-incrementing
// SDRAM pointer, drop counter and a toggle-handshake SDRAM port.
// Optional: define API_READBACK_EN to implement the READ command; otherwise
// READ is rejected and no SDRAM read is ever made.
module api_mapper #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 16,
  parameter int REGIONS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [5:0]                   req_cmd,
  input  logic [31:0]                  req_arg,
  output logic                         resp_valid,
  output logic [31:0]                  resp_arg,
  output logic                         resp_err,
  output logic                         ram_req,
  input  logic                         ram_ack,
  output logic                         ram_we,
  output logic [ADDR_BITS-1:0]         ram_address,
  output logic [DATA_BITS-1:0]         ram_data_write,
  input  logic [DATA_BITS-1:0]         ram_data_read,
  output logic [REGIONS*ADDR_BITS-1:0] region_offset,
  output logic                         write_active
);
  import api_pkg::*;

  localparam int PTR_W = (ADDR_BITS < 24) ? ADDR_BITS : 24;

  state_e                     state_q, state_d;
  logic                       issue, issue_we, imm, imm_err, done, arg_hi_nz, drop;
  logic [31:0]                imm_arg;
  logic [DATA_BITS-1:0]       rdata;
  logic [ADDR_BITS-1:0]       pointer, new_off;
  logic [ADDR_BITS-1:0]       offsets [REGIONS];
  logic [DROP_CNT_BITS-1:0]   drop_cnt;
  logic [3:0]                 region;
  logic [4:0]                 shift;
  logic [23:0]                ptr24;

  assign region  = req_arg[REGION_MSB:REGION_LSB];
  assign shift   = req_arg[SHIFT_MSB:SHIFT_LSB];
  assign new_off = (shift == 5'd0) ? '0 : (ADDR_BITS'(1) << shift);
  assign ptr24   = 24'(pointer[PTR_W-1:0]);
  assign drop    = req_valid && (state_q != ST_IDLE);

  if (ADDR_BITS < 32) begin : g_hi
    assign arg_hi_nz = |req_arg[31:ADDR_BITS];
  end else begin : g_nohi
    assign arg_hi_nz = 1'b0;
  end

  for (genvar i = 0; i < REGIONS; i++) begin : g_pack
    assign region_offset[i*ADDR_BITS +: ADDR_BITS] = offsets[i];
  end

  api_ram_port #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_ram_port (
    .clk            (clk),
    .rst            (rst),
    .issue          (issue),
    .issue_we       (issue_we),
    .issue_addr     (pointer),
    .issue_data     (req_arg[DATA_BITS-1:0]),
    .done           (done),
    .rdata          (rdata),
    .ram_req        (ram_req),
    .ram_ack        (ram_ack),
    .ram_we         (ram_we),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_data_read  (ram_data_read)
  );

`ifndef API_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, access launch and immediate-command decode.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    issue_we = 1'b0;
    imm      = 1'b0;
    imm_err  = 1'b0;
    imm_arg  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_cmd == CMD_WRITE) begin
            issue    = 1'b1;
            issue_we = 1'b1;
            state_d  = ST_RAM_WAIT;
`ifdef API_READBACK_EN
          end else if (req_cmd == CMD_READ) begin
            issue    = 1'b1;
            state_d  = ST_RAM_WAIT;
`endif
          end else begin
            imm = 1'b1;
          end
        end
      end
      ST_RAM_WAIT: if (done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    case (req_cmd)
      CMD_SET_OFFSET: imm_err = (32'(region) >= REGIONS) || (32'(shift) >= ADDR_BITS);
      CMD_LOAD_BEGIN,
      CMD_LOAD_END:   imm_err = 1'b0;
      CMD_SET_PTR:    imm_err = arg_hi_nz;
      CMD_STATUS:     imm_arg = {ptr24, drop_cnt};
      default:        imm_err = 1'b1;
    endcase
  end

  // Response strobe: immediate commands and completed SDRAM accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_arg   <= '0;
    end else begin
      resp_valid <= imm || done;
      resp_err   <= imm && imm_err;
      if (imm) begin
        resp_arg <= imm_arg;
      end else if (done) begin
`ifdef API_READBACK_EN
        resp_arg <= ram_we ? 32'd0 : 32'(rdata);
`else
        resp_arg <= 32'd0;
`endif
      end
    end
  end

  // Pointer, load flag and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer      <= '0;
      write_active <= 1'b1;
      drop_cnt     <= '0;
    end else begin
      if (done) pointer <= pointer + ADDR_BITS'(1);
      else if (imm && req_cmd == CMD_SET_PTR && !imm_err) pointer <= req_arg[ADDR_BITS-1:0];
      if (imm && req_cmd == CMD_LOAD_BEGIN) write_active <= 1'b1;
      if (imm && req_cmd == CMD_LOAD_END)   write_active <= 1'b0;
      if (imm && req_cmd == CMD_STATUS)
        drop_cnt <= drop ? DROP_CNT_BITS'(1) : '0;
      else if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_CNT_BITS'(1);
    end
  end

  // Region base offsets, written only by an accepted SET_OFFSET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGIONS; i++) offsets[i] <= '0;
    end else if (imm && req_cmd == CMD_SET_OFFSET && !imm_err) begin
      for (int i = 0; i < REGIONS; i++)
        if (region == 4'(i)) offsets[i] <= new_off;
    end
  end

endmodule

// File: tb/tb_api_mapper.sv
// Self-checking bench for api_mapper (ADDR_BITS=24, DATA_BITS=16, REGIONS=4).
// Expected responses are queued as commands are driven and compared by a
// monitor as resp_valid strobes appear.
module tb_api_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_cmd = '0;
  logic [31:0] req_arg = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_arg;
  logic        ram_req, ram_we;
  logic        ram_ack = 1'b0;
  logic [23:0] ram_address;
  logic [15:0] ram_data_write;
  logic [15:0] ram_data_read = '0;
  logic [95:0] region_offset;
  logic        write_active;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic        chk_arg;
    logic [31:0] arg;
  } exp_t;
  exp_t exp_q[$];

  api_mapper #(.ADDR_BITS(24), .DATA_BITS(16), .REGIONS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_arg(req_arg),
    .resp_valid(resp_valid), .resp_arg(resp_arg), .resp_err(resp_err),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_we(ram_we), .ram_address(ram_address),
    .ram_data_write(ram_data_write), .ram_data_read(ram_data_read),
    .region_offset(region_offset), .write_active(write_active)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got err=%0b arg=%h, required no response", resp_err, resp_arg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (resp_err !== e.err || (e.chk_arg && resp_arg !== e.arg)) begin
          errors++;
          $display("FAIL resp: got err=%0b arg=%h, required err=%0b arg=%h", resp_err, resp_arg, e.err, e.arg);
        end
      end
    end
  end

  task automatic push_exp(input logic err, input logic chk, input logic [31:0] arg);
    exp_q.push_back('{err: err, chk_arg: chk, arg: arg});
  endtask

  // One-cycle command strobe; returns #1 after the sampling edge.
  task automatic send(input logic [5:0] cmd, input logic [31:0] arg);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_arg = arg;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (write_active !== 1'b1 || ram_req !== 1'b0 || ram_we !== 1'b0 || ram_address !== 24'h0 ||
        ram_data_write !== 16'h0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_arg !== 32'h0 ||
        region_offset !== 96'h0) begin
      errors++;
      $display("FAIL reset_state: got wa=%0b req=%0b we=%0b addr=%h rv=%0b offs=%h, required wa=1 others 0",
               write_active, ram_req, ram_we, ram_address, resp_valid, region_offset);
    end
    @(negedge clk) rst = 1'b0;
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd7, 32'h0);
  endtask

  task automatic test_set_offset;
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd1, 32'h0000_1101);
    checks++;
    if (resp_valid !== 1'b1 || region_offset !== 96'h000000_000000_020000_000000) begin
      errors++;
      $display("FAIL set_offset_r1: got rv=%0b offs=%h, required rv=1 offs=%h", resp_valid, region_offset,
               96'h000000_000000_020000_000000);
    end
    push_exp(1'b1, 1'b0, 32'h0);
    send(6'd1, 32'h0000_0405);
    push_exp(1'b1, 1'b0, 32'h0);
    send(6'd1, 32'h0000_1800);
    checks++;
    if (region_offset !== 96'h000000_000000_020000_000000) begin
      errors++;
      $display("FAIL set_offset_bad: got offs=%h, required unchanged", region_offset);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd1, 32'h0000_1703);
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd1, 32'h0000_0002);
    checks++;
    if (region_offset !== 96'h800000_000000_020000_000000) begin
      errors++;
      $display("FAIL set_offset_edge: got offs=%h, required %h", region_offset, 96'h800000_000000_020000_000000);
    end
  endtask

  task automatic test_load;
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd3, 32'hFFFF_FFFF);
    checks++;
    if (write_active !== 1'b0) begin
      errors++;
      $display("FAIL load_end: got wa=%0b, required 0", write_active);
    end
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd2, 32'h0);
    checks++;
    if (write_active !== 1'b1) begin
      errors++;
      $display("FAIL load_begin: got wa=%0b, required 1", write_active);
    end
    push_exp(1'b1, 1'b1, 32'h0);
    send(6'd0, 32'h1234);
    push_exp(1'b1, 1'b1, 32'h0);
    send(6'd9, 32'h1234);
  endtask

  task automatic test_write_wrap;
    logic r0;
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd4, 32'h00FF_FFFF);
    push_exp(1'b1, 1'b0, 32'h0);
    send(6'd4, 32'h0100_0000);
    push_exp(1'b0, 1'b1, {24'hFFFFFF, 8'h0});
    send(6'd7, 32'h0);
    r0 = ram_req;
    send(6'd5, 32'h0000_BEEF);
    checks++;
    if (ram_req !== ~r0 || ram_address !== 24'hFFFFFF || ram_we !== 1'b1 || ram_data_write !== 16'hBEEF ||
        resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_issue: got req=%0b addr=%h we=%0b data=%h rv=%0b, required req=%0b addr=ffffff we=1 data=beef rv=0",
               ram_req, ram_address, ram_we, ram_data_write, resp_valid, ~r0);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (ram_req !== ~r0 || ram_address !== 24'hFFFFFF || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL write_wait: got req=%0b addr=%h rv=%0b, required stable and no response",
                 ram_req, ram_address, resp_valid);
      end
    end
    push_exp(1'b0, 1'b1, 32'h0);
    @(negedge clk) ram_ack = ram_req;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || ram_req !== ~r0) begin
      errors++;
      $display("FAIL write_done: got rv=%0b req=%0b, required rv=1 req=%0b", resp_valid, ram_req, ~r0);
    end
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd7, 32'h0);
  endtask

  task automatic test_drops;
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd4, 32'h0000_0100);
    send(6'd5, 32'h0000_0001);
    send(6'd7, 32'h0);
    send(6'd1, 32'h0000_0501);
    @(negedge clk) ram_ack = ram_req;
    push_exp(1'b0, 1'b1, 32'h0);
    push_exp(1'b0, 1'b1, {24'h000101, 8'd2});
    send(6'd7, 32'h0);
    push_exp(1'b0, 1'b1, {24'h000101, 8'd0});
    send(6'd7, 32'h0);
    checks++;
    if (region_offset !== 96'h800000_000000_020000_000000) begin
      errors++;
      $display("FAIL drop_no_effect: got offs=%h, required unchanged", region_offset);
    end
    send(6'd5, 32'h0000_0002);
    @(negedge clk);
    ram_ack = ram_req;
    req_valid = 1'b1; req_cmd = 6'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_exp(1'b0, 1'b1, 32'h0);
    push_exp(1'b0, 1'b1, {24'h000102, 8'd1});
    send(6'd7, 32'h0);
  endtask

  task automatic test_back_to_back;
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, {24'h000055, 8'd0});
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 6'd4; req_arg = 32'h55;
    @(negedge clk);
    req_cmd = 6'd7; req_arg = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_read;
    logic r0;
    push_exp(1'b0, 1'b0, 32'h0);
    send(6'd4, 32'h0000_0010);
    ram_data_read = 16'h1234;
    r0 = ram_req;
`ifdef API_READBACK_EN
    send(6'd6, 32'h0);
    checks++;
    if (ram_req !== ~r0 || ram_we !== 1'b0 || ram_address !== 24'h000010) begin
      errors++;
      $display("FAIL read_issue: got req=%0b we=%0b addr=%h, required req=%0b we=0 addr=000010",
               ram_req, ram_we, ram_address, ~r0);
    end
    push_exp(1'b0, 1'b1, 32'h0000_1234);
    @(negedge clk) ram_ack = ram_req;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b1, {24'h000011, 8'd0});
    send(6'd7, 32'h0);
`else
    push_exp(1'b1, 1'b0, 32'h0);
    send(6'd6, 32'h0);
    checks++;
    if (ram_req !== r0 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_disabled: got req=%0b rv=%0b, required req=%0b rv=1", ram_req, resp_valid, r0);
    end
    push_exp(1'b0, 1'b1, {24'h000010, 8'd0});
    send(6'd7, 32'h0);
`endif
  endtask

  task automatic test_reset_mid;
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd3, 32'h0);
    send(6'd5, 32'h0000_AAAA);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (write_active !== 1'b1 || region_offset !== 96'h0 || ram_req !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got wa=%0b offs=%h req=%0b rv=%0b, required wa=1 offs=0 req=0 rv=0",
               write_active, region_offset, ram_req, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    ram_ack = 1'b0;
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd3, 32'h0);
    checks++;
    if (resp_valid !== 1'b1 || write_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got rv=%0b wa=%0b, required rv=1 wa=0", resp_valid, write_active);
    end
    push_exp(1'b0, 1'b1, 32'h0);
    send(6'd7, 32'h0);
  endtask

  initial begin
    test_reset();
    test_set_offset();
    test_load();
    test_write_wrap();
    test_drops();
    test_back_to_back();
    test_read();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
